// File: rtl/dmem_port_arbiter.sv
// Core-first arbiter sharing one synchronous data memory port between the core and a DMA master.
// Grant is combinational; the response returns one cycle later. `define DMEM_ARB_FAIRNESS_EN to enable the DMA starvation guard.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 30
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [3:0]        c_wstrb,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_fault,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_fault,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_wstrb,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_fault
);

    typedef enum logic [1:0] {IDLE, RESP_C, RESP_D} owner_e;

    owner_e owner_q, owner_d;
    logic   rd_q, rd_d;
    logic   force_d;

    // Grants are held off during reset so nothing is accepted that reset would orphan.
    assign c_gnt = rst_n && c_req && !force_d;
    assign d_gnt = rst_n && d_req && (!c_req || force_d);
    assign m_en  = c_gnt | d_gnt;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wstrb = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wstrb = c_wstrb;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wstrb = d_wstrb;
            m_wdata = d_wdata;
        end
    end

    always_comb begin
        owner_d  = IDLE;
        rd_d     = 1'b0;
        c_rvalid = 1'b0;
        c_rdata  = '0;
        c_fault  = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_fault  = 1'b0;
        if (c_gnt) begin
            owner_d = RESP_C;
            rd_d    = !c_we;
        end else if (d_gnt) begin
            owner_d = RESP_D;
            rd_d    = !d_we;
        end
        // Write responses return zero data so stale memory output never leaks.
        case (owner_q)
            RESP_C: begin
                c_rvalid = 1'b1;
                c_rdata  = rd_q ? m_rdata : 32'h0;
                c_fault  = m_fault;
            end
            RESP_D: begin
                d_rvalid = 1'b1;
                d_rdata  = rd_q ? m_rdata : 32'h0;
                d_fault  = m_fault;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= IDLE;
            rd_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            rd_q    <= rd_d;
        end
    end

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Counts consecutive cycles the DMA master lost to the core.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!d_req || d_gnt) begin
            starve_cnt_d = '0;
        end else if (c_req && starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_d = (starve_cnt_q == LIMIT);
`else
    // Keeps the limit parameter referenced when the guard is compiled out.
    logic [3:0] limit_unused;
    assign limit_unused = 4'(STARVE_LIMIT);
    assign force_d      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_port_arbiter;
    localparam int AW    = 30;
    localparam int LIMIT = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req, c_we, c_gnt, c_rvalid, c_fault;
    logic [AW-1:0] c_addr;
    logic [3:0]    c_wstrb;
    logic [31:0]   c_wdata, c_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_fault;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_wstrb;
    logic [31:0]   d_wdata, d_rdata;
    logic          m_en, m_we, m_fault;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_wdata, m_rdata;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        fault_sel;

    int total = 0;
    int bad   = 0;

    int          losses;
    int          resp_who;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic        exp_cg, exp_dg;

    dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wstrb(c_wstrb), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_fault(c_fault),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_fault(m_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Synchronous memory: read data one cycle after m_en, garbage otherwise.
    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr[5:0]] <= merge(mem[m_addr[5:0]], m_wdata, m_wstrb);
        if (m_en && !m_we) m_rdata <= mem[m_addr[5:0]];
        else m_rdata <= $urandom;
        m_fault <= m_en && fault_sel;
    end

    task automatic drive_idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wstrb = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wstrb = 0; d_wdata = 0;
        fault_sel = 0;
    endtask

    task automatic model_grant();
        bit force_dma;
        force_dma = FAIR && (losses == LIMIT);
        exp_cg = 0;
        exp_dg = 0;
        if (rst_n) begin
            if (d_req && (force_dma || !c_req)) exp_dg = 1;
            else if (c_req) exp_cg = 1;
        end
    endtask

    task automatic model_commit();
        logic [5:0] a;
        resp_who = 0; resp_data = 0; resp_fault = 0;
        if (!rst_n) begin
            losses = 0;
            return;
        end
        if (exp_cg || exp_dg) begin
            resp_who   = exp_cg ? 1 : 2;
            a          = exp_cg ? c_addr[5:0] : d_addr[5:0];
            resp_fault = fault_sel;
            if ((exp_cg ? c_we : d_we) == 1'b0) resp_data = ref_mem[a];
            else ref_mem[a] = merge(ref_mem[a], exp_cg ? c_wdata : d_wdata, exp_cg ? c_wstrb : d_wstrb);
        end
        if (!d_req || exp_dg) losses = 0;
        else if (c_req && losses < LIMIT) losses++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rst_n = 0; drive_idle(); c_req = 1; d_req = 1;
            #1; model_grant();
            total++; if ({c_gnt, d_gnt, m_en} !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b expected 000", {c_gnt, d_gnt, m_en}); end
            model_commit();
        end
        @(negedge clk); rst_n = 1; drive_idle();
        #1; model_grant();
        total++; if ({c_rvalid, d_rvalid, c_fault, d_fault} !== 4'b0) begin bad++; $display("FAIL reset_resp: got %b expected 0000", {c_rvalid, d_rvalid, c_fault, d_fault}); end
        total++; if ({c_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", {c_rdata, d_rdata}); end
        total++; if ({m_en, m_we, m_addr, m_wstrb, m_wdata} !== '0) begin bad++; $display("FAIL reset_mbus: got %h expected 0", {m_en, m_we, m_addr, m_wstrb, m_wdata}); end
        model_commit();
    endtask

    task automatic test_core_read();
        @(negedge clk); drive_idle(); c_req = 1; c_addr = 30'h10;
        #1; model_grant();
        total++; if ({c_gnt, d_gnt, m_en, m_we} !== 4'b1010) begin bad++; $display("FAIL core_read_gnt: got %b expected 1010", {c_gnt, d_gnt, m_en, m_we}); end
        total++; if (m_addr !== 30'h10) begin bad++; $display("FAIL core_read_addr: got %h expected 10", m_addr); end
        model_commit();
        @(negedge clk); drive_idle();
        #1; model_grant();
        total++; if ({c_rvalid, d_rvalid} !== 2'b10) begin bad++; $display("FAIL core_read_rvalid: got %b expected 10", {c_rvalid, d_rvalid}); end
        total++; if (c_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL core_read_data: got %h expected deadbeef", c_rdata); end
        model_commit();
    endtask

    task automatic test_contention();
        @(negedge clk); drive_idle();
        c_req = 1; c_we = 1; c_addr = 30'h4; c_wstrb = 4'hF; c_wdata = 32'hA5A50004;
        d_req = 1; d_we = 1; d_addr = 30'h8; d_wstrb = 4'hF; d_wdata = 32'h5A5A0008;
        #1; model_grant();
        total++; if ({c_gnt, d_gnt, m_we} !== 3'b101) begin bad++; $display("FAIL contention_gnt: got %b expected 101", {c_gnt, d_gnt, m_we}); end
        total++; if ({m_addr, m_wdata} !== {30'h4, 32'hA5A50004}) begin bad++; $display("FAIL contention_core_bus: got %h/%h expected 4/a5a50004", m_addr, m_wdata); end
        model_commit();
        @(negedge clk); c_req = 0;
        #1; model_grant();
        total++; if ({c_gnt, d_gnt, m_en} !== 3'b011) begin bad++; $display("FAIL contention_dma_gnt: got %b expected 011", {c_gnt, d_gnt, m_en}); end
        total++; if ({m_addr, m_wdata} !== {30'h8, 32'h5A5A0008}) begin bad++; $display("FAIL contention_dma_bus: got %h/%h expected 8/5a5a0008", m_addr, m_wdata); end
        total++; if ({c_rvalid, c_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL contention_core_resp: got %b/%h expected 1/0", c_rvalid, c_rdata); end
        model_commit();
        @(negedge clk); drive_idle();
        #1; model_grant();
        total++; if ({d_rvalid, c_rvalid, d_rdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL contention_dma_resp: got %b%b/%h expected 10/0", d_rvalid, c_rvalid, d_rdata); end
        total++; if (mem[8] !== 32'h5A5A0008) begin bad++; $display("FAIL contention_mem8: got %h expected 5a5a0008", mem[8]); end
        model_commit();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); drive_idle(); c_req = 1; c_addr = 30'h1;
        #1; model_grant();
        total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL b2b_c1_gnt: got %b expected 1", c_gnt); end
        model_commit();
        @(negedge clk); drive_idle(); d_req = 1; d_addr = 30'h2;
        #1; model_grant();
        total++; if ({d_gnt, c_rvalid, d_rvalid, c_rdata} !== {3'b110, 32'h11111111}) begin bad++; $display("FAIL b2b_core_resp: got %b%b%b/%h expected 110/11111111", d_gnt, c_rvalid, d_rvalid, c_rdata); end
        model_commit();
        @(negedge clk); drive_idle(); c_req = 1; c_we = 1; c_addr = 30'h3; c_wstrb = 4'h0; c_wdata = 32'hFFFFFFFF;
        #1; model_grant();
        total++; if ({c_gnt, m_en, m_we, m_wstrb} !== 7'b1110000) begin bad++; $display("FAIL b2b_zero_strb: got %b expected 1110000", {c_gnt, m_en, m_we, m_wstrb}); end
        total++; if ({d_rvalid, c_rvalid, d_rdata} !== {2'b10, 32'h22222222}) begin bad++; $display("FAIL b2b_dma_resp: got %b%b/%h expected 10/22222222", d_rvalid, c_rvalid, d_rdata); end
        model_commit();
        @(negedge clk); drive_idle();
        #1; model_grant();
        total++; if ({c_rvalid, d_rvalid, c_rdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL b2b_write_resp: got %b%b/%h expected 10/0", c_rvalid, d_rvalid, c_rdata); end
        total++; if (mem[3] !== 32'h33333333) begin bad++; $display("FAIL b2b_mem3_kept: got %h expected 33333333", mem[3]); end
        model_commit();
    endtask

    task automatic test_fault();
        @(negedge clk); drive_idle(); d_req = 1; d_addr = 30'h5; fault_sel = 1;
        #1; model_grant();
        total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL fault_gnt: got %b expected 1", d_gnt); end
        model_commit();
        @(negedge clk); drive_idle();
        #1; model_grant();
        total++; if ({d_rvalid, d_fault, c_rvalid, c_fault} !== 4'b1100) begin bad++; $display("FAIL fault_route: got %b expected 1100", {d_rvalid, d_fault, c_rvalid, c_fault}); end
        total++; if (d_rdata !== ref_mem[5]) begin bad++; $display("FAIL fault_rdata: got %h expected %h", d_rdata, ref_mem[5]); end
        model_commit();
    endtask

    task automatic test_starvation();
`ifdef DMEM_ARB_FAIRNESS_EN
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); drive_idle(); c_req = 1; d_req = 1;
            c_addr = 30'($urandom_range(0, 63)); d_addr = 30'($urandom_range(0, 63));
            #1; model_grant();
            total++;
            if ({c_gnt, d_gnt} !== ((i == 5) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL starve_cycle%0d: got %b expected %b", i, {c_gnt, d_gnt}, (i == 5) ? 2'b01 : 2'b10);
            end
            model_commit();
        end
`else
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk); drive_idle(); c_req = 1; d_req = 1;
            c_addr = 30'($urandom_range(0, 63)); d_addr = 30'($urandom_range(0, 63));
            #1; model_grant();
            total++; if ({c_gnt, d_gnt} !== 2'b10) begin bad++; $display("FAIL strict_cycle%0d: got %b expected 10", i, {c_gnt, d_gnt}); end
            model_commit();
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive_idle(); c_req = 1; c_addr = 30'h7;
        #1; model_grant();
        total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL rmid_accept: got %b expected 1", c_gnt); end
        model_commit();
        @(negedge clk); rst_n = 0; c_req = 1; d_req = 1;
        #1; model_grant();
        total++; if ({c_gnt, d_gnt, m_en} !== 3'b000) begin bad++; $display("FAIL rmid_gnt: got %b expected 000", {c_gnt, d_gnt, m_en}); end
        model_commit();
        @(negedge clk); rst_n = 1; drive_idle();
        #1; model_grant();
        total++; if ({c_rvalid, d_rvalid, c_fault, d_fault, c_rdata, d_rdata} !== '0) begin bad++; $display("FAIL rmid_resp: got %b%b%b%b/%h/%h expected all 0", c_rvalid, d_rvalid, c_fault, d_fault, c_rdata, d_rdata); end
        model_commit();
    endtask

    task automatic test_random();
        logic [66:0] exp_bus;
        logic [33:0] exp_c, exp_d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 49) != 0);
            c_req   = ($urandom_range(0, 9) < 6);
            c_we    = $urandom_range(0, 1);
            c_addr  = 30'($urandom_range(0, 63));
            c_wstrb = 4'($urandom);
            c_wdata = $urandom;
            d_req   = ($urandom_range(0, 9) < 5);
            d_we    = $urandom_range(0, 1);
            d_addr  = 30'($urandom_range(0, 63));
            d_wstrb = 4'($urandom);
            d_wdata = $urandom;
            fault_sel = ($urandom_range(0, 7) == 0);
            #1; model_grant();
            exp_bus = '0;
            if (exp_cg) exp_bus = {c_we, c_addr, c_wstrb, c_wdata};
            else if (exp_dg) exp_bus = {d_we, d_addr, d_wstrb, d_wdata};
            exp_c = {resp_who == 1, (resp_who == 1) && resp_fault, (resp_who == 1) ? resp_data : 32'h0};
            exp_d = {resp_who == 2, (resp_who == 2) && resp_fault, (resp_who == 2) ? resp_data : 32'h0};
            total++; if ({c_gnt, d_gnt, m_en} !== {exp_cg, exp_dg, exp_cg | exp_dg}) begin bad++; $display("FAIL rnd%0d_gnt: got %b expected %b", i, {c_gnt, d_gnt, m_en}, {exp_cg, exp_dg, exp_cg | exp_dg}); end
            total++; if ({m_we, m_addr, m_wstrb, m_wdata} !== exp_bus) begin bad++; $display("FAIL rnd%0d_mbus: got %h expected %h", i, {m_we, m_addr, m_wstrb, m_wdata}, exp_bus); end
            total++; if ({c_rvalid, c_fault, c_rdata} !== exp_c) begin bad++; $display("FAIL rnd%0d_core_resp: got %h expected %h", i, {c_rvalid, c_fault, c_rdata}, exp_c); end
            total++; if ({d_rvalid, d_fault, d_rdata} !== exp_d) begin bad++; $display("FAIL rnd%0d_dma_resp: got %h expected %h", i, {d_rvalid, d_fault, d_rdata}, exp_d); end
            model_commit();
        end
    endtask

    initial begin
        drive_idle();
        losses = 0; resp_who = 0; resp_data = 0; resp_fault = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        mem[1]  = 32'h11111111; ref_mem[1]  = 32'h11111111;
        mem[2]  = 32'h22222222; ref_mem[2]  = 32'h22222222;
        mem[3]  = 32'h33333333; ref_mem[3]  = 32'h33333333;

        test_reset();
        test_core_read();
        test_contention();
        test_back_to_back();
        test_fault();
        test_starvation();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
